// File: rtl/lock_controller.sv
// Keypad lock sequencer: PIN check, timed unlock, retry lockout and PIN reprogramming.
// All outputs registered; every decision lands one cycle after the causing key or prog_req.
module lock_controller #(
  parameter int PIN_LEN = 4,
  parameter int MAX_TRIES = 3,
  parameter int UNLOCK_CYC = 5000,
  parameter int LOCKOUT_CYC = 30000,
  parameter int ENTRY_TO_CYC = 20000,
  parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  input  logic                           prog_req,
  output logic                           unlock,
  output logic                           locked_out,
  output logic                           prog_mode,
  output logic                           ok_pulse,
  output logic                           err_pulse,
  output logic [$clog2(PIN_LEN+1)-1:0]   digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int BW = 4 * PIN_LEN;
  localparam int CW = $clog2(PIN_LEN + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);
  localparam int MAX_A = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int MAX_C = (MAX_A > ENTRY_TO_CYC) ? MAX_A : ENTRY_TO_CYC;
  localparam int TW = $clog2(MAX_C);

  localparam logic [TW-1:0] UNL_LD = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] LCK_LD = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] ETO_LD = TW'(ENTRY_TO_CYC - 1);
  localparam logic [RW-1:0] TRIES_LD = RW'(MAX_TRIES);
  localparam logic [CW-1:0] FULL_CNT = CW'(PIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCKED,
    S_LOCKOUT,
    S_PROG
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   pin_reg, pin_n;
  logic [BW-1:0]   buffer, buf_n;
  logic [CW-1:0]   cnt_n;
  logic            ovf, ovf_n;
  logic [RW-1:0]   tries_n;
  logic [TW-1:0]   timer, timer_n;
  logic            ok_n, err_n;
  logic            key_acc;
  logic            is_digit, is_star, is_hash, timer_zero, entry_full;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_star    = key_valid && (key_code == 4'hA);
  assign is_hash    = key_valid && (key_code == 4'hB);
  assign timer_zero = (timer == '0);
  assign entry_full = (digit_cnt == FULL_CNT) && !ovf;

  always_comb begin
    state_n = state;
    pin_n   = pin_reg;
    buf_n   = buffer;
    cnt_n   = digit_cnt;
    ovf_n   = ovf;
    tries_n = tries_left;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    key_acc = 1'b0;
    timer_n = timer_zero ? timer : timer - TW'(1);

    // ENTRY and PROG share the digit buffering; a full buffer only flags overflow
    if ((state == S_ENTRY || state == S_PROG) && is_digit) begin
      key_acc = 1'b1;
      if (digit_cnt == FULL_CNT) begin
        ovf_n = 1'b1;
      end else begin
        buf_n = (buffer << 4) | {{(BW-4){1'b0}}, key_code};
        cnt_n = digit_cnt + CW'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (is_digit) begin
          state_n = S_ENTRY;
          buf_n   = {{(BW-4){1'b0}}, key_code};
          cnt_n   = CW'(1);
        end
      end
      S_ENTRY: begin
        if (is_star) begin
          key_acc = 1'b1;
          buf_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end else if (is_hash) begin
          key_acc = 1'b1;
          if (entry_full && buffer == pin_reg) begin
            state_n = S_UNLOCKED;
            ok_n    = 1'b1;
            tries_n = TRIES_LD;
          end else begin
            err_n   = 1'b1;
            tries_n = tries_left - RW'(1);
            state_n = (tries_left == RW'(1)) ? S_LOCKOUT : S_IDLE;
          end
        end else if (!is_digit && timer_zero) begin
          state_n = S_IDLE;
        end
      end
      S_UNLOCKED: begin
        if (prog_req) begin
          state_n = S_PROG;
        end else if (is_hash || timer_zero) begin
          state_n = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (timer_zero) begin
          state_n = S_IDLE;
          tries_n = TRIES_LD;
        end
      end
      S_PROG: begin
        if (is_star) begin
          state_n = S_IDLE;
        end else if (is_hash) begin
          key_acc = 1'b1;
          if (entry_full) begin
            pin_n   = buffer;
            ok_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n = 1'b1;
            buf_n = '0;
            cnt_n = '0;
            ovf_n = 1'b0;
          end
        end else if (!is_digit && timer_zero) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Leaving the digit-collecting states always discards the partial entry
    if (state_n != S_ENTRY && state_n != S_PROG) begin
      buf_n = '0;
      cnt_n = '0;
      ovf_n = 1'b0;
    end

    if (state_n != state || key_acc) begin
      case (state_n)
        S_UNLOCKED: timer_n = UNL_LD;
        S_LOCKOUT:  timer_n = LCK_LD;
        default:    timer_n = ETO_LD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pin_reg    <= DEFAULT_PIN;
      buffer     <= '0;
      digit_cnt  <= '0;
      ovf        <= 1'b0;
      tries_left <= TRIES_LD;
      timer      <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      prog_mode  <= 1'b0;
      ok_pulse   <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      pin_reg    <= pin_n;
      buffer     <= buf_n;
      digit_cnt  <= cnt_n;
      ovf        <= ovf_n;
      tries_left <= tries_n;
      timer      <= timer_n;
      unlock     <= (state_n == S_UNLOCKED);
      locked_out <= (state_n == S_LOCKOUT);
      prog_mode  <= (state_n == S_PROG);
      ok_pulse   <= ok_n;
      err_pulse  <= err_n;
    end
  end

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios with literal expectations, then random traffic vs a queue-based model.
module tb_lock_controller;
  localparam int PL = 4;
  localparam int MT = 3;
  localparam int UC = 8;
  localparam int LC = 16;
  localparam int EC = 10;

  localparam int M_IDLE = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN = 2;
  localparam int M_LOCK = 3;
  localparam int M_PROG = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       prog_req = 1'b0;
  logic       unlock, locked_out, prog_mode, ok_pulse, err_pulse;
  logic [2:0] digit_cnt;
  logic [1:0] tries_left;

  lock_controller #(
    .PIN_LEN(PL), .MAX_TRIES(MT), .UNLOCK_CYC(UC), .LOCKOUT_CYC(LC),
    .ENTRY_TO_CYC(EC), .DEFAULT_PIN(16'h1234)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .prog_req(prog_req), .unlock(unlock), .locked_out(locked_out),
    .prog_mode(prog_mode), .ok_pulse(ok_pulse), .err_pulse(err_pulse),
    .digit_cnt(digit_cnt), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, digit queue, absolute deadline cycle
  int     m = M_IDLE;
  int     q[$];
  bit     ovf = 1'b0;
  int     tries = MT;
  int     pin[PL] = '{1, 2, 3, 4};
  longint cyc = 0;
  longint dl = 0;
  bit     e_ok = 1'b0;
  bit     e_err = 1'b0;
  bit     chk_en = 1'b0;

  function automatic bit q_full_ok();
    return (q.size() == PL) && !ovf;
  endfunction

  task automatic add_digit(input int d);
    if (q.size() == PL) ovf = 1'b1;
    else q.push_back(d);
    dl = cyc + EC;
  endtask

  task automatic model_step();
    bit dig, star, hash, expired, match;
    dig = key_valid && key_code <= 4'd9;
    star = key_valid && key_code == 4'hA;
    hash = key_valid && key_code == 4'hB;
    expired = (cyc >= dl);
    e_ok = 1'b0;
    e_err = 1'b0;
    if (!rst) begin
      m = M_IDLE; pin = '{1, 2, 3, 4}; tries = MT;
    end else begin
      case (m)
        M_IDLE: if (dig) begin m = M_ENTRY; q = {}; q.push_back(int'(key_code)); ovf = 0; dl = cyc + EC; end
        M_ENTRY: begin
          if (dig) add_digit(int'(key_code));
          else if (star) begin q = {}; ovf = 0; dl = cyc + EC; end
          else if (hash) begin
            match = q_full_ok();
            for (int i = 0; i < PL; i++) if (match && q[i] != pin[i]) match = 0;
            if (match) begin m = M_OPEN; e_ok = 1; tries = MT; dl = cyc + UC; end
            else begin
              e_err = 1; tries = tries - 1;
              if (tries == 0) begin m = M_LOCK; dl = cyc + LC; end
              else m = M_IDLE;
            end
          end else if (expired) m = M_IDLE;
        end
        M_OPEN: begin
          if (prog_req) begin m = M_PROG; dl = cyc + EC; end
          else if (hash || expired) m = M_IDLE;
        end
        M_LOCK: if (expired) begin m = M_IDLE; tries = MT; end
        M_PROG: begin
          if (dig) add_digit(int'(key_code));
          else if (star) m = M_IDLE;
          else if (hash) begin
            if (q_full_ok()) begin
              for (int i = 0; i < PL; i++) pin[i] = q[i];
              e_ok = 1; m = M_IDLE;
            end else begin e_err = 1; q = {}; ovf = 0; dl = cyc + EC; end
          end else if (expired) m = M_IDLE;
        end
        default: m = M_IDLE;
      endcase
    end
    if (m != M_ENTRY && m != M_PROG) begin q = {}; ovf = 0; end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step();
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({unlock, locked_out, prog_mode, ok_pulse, err_pulse, digit_cnt, tries_left} !==
          {m == M_OPEN, m == M_LOCK, m == M_PROG, e_ok, e_err, 3'(q.size()), 2'(tries)}) begin
        errors++;
        $display("FAIL model cyc=%0d got u=%b lo=%b pm=%b ok=%b err=%b cnt=%0d tries=%0d exp u=%b lo=%b pm=%b ok=%b err=%b cnt=%0d tries=%0d",
                 cyc, unlock, locked_out, prog_mode, ok_pulse, err_pulse, digit_cnt, tries_left,
                 m == M_OPEN, m == M_LOCK, m == M_PROG, e_ok, e_err, q.size(), tries);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d); press(4'hB);
  endtask

  task automatic prog_pulse(input bit with_key, input logic [3:0] k);
    prog_req = 1'b1;
    key_valid = with_key;
    key_code = k;
    @(negedge clk);
    prog_req = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int p[PL];
    idle(2);
    rst = 1'b1;
    chk("reset_tries", int'(tries_left), 3);
    chk("reset_unlock", int'(unlock), 0);
    chk("reset_cnt", int'(digit_cnt), 0);

    // correct default PIN, unlock window length
    enter4(1, 2, 3, 4);
    chk("t1_ok", int'(ok_pulse), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (unlock) cnt++;
      @(negedge clk);
    end
    chk("t1_unlock_len", cnt, 8);

    // three wrong PINs -> lockout, keys ignored, tries restored
    enter4(1, 2, 3, 5);
    chk("t2_err", int'(err_pulse), 1);
    chk("t2_tries", int'(tries_left), 2);
    enter4(1, 2, 3, 5);
    enter4(1, 2, 3, 5);
    chk("t2_lock", int'(locked_out), 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (locked_out) cnt++;
      key_valid = (i < 12);
      key_code = 4'(i);
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("t2_lock_len", cnt, 16);
    chk("t2_tries_back", int'(tries_left), 3);

    // entry timeout boundary and overflow
    press(1); press(2); press(3);
    idle(9);
    chk("t3_cnt_before_to", int'(digit_cnt), 3);
    idle(1);
    chk("t3_cnt_after_to", int'(digit_cnt), 0);
    chk("t3_tries_kept", int'(tries_left), 3);
    press(1); press(2); press(3); press(4); press(4); press(4'hB);
    chk("t3_ovf_err", int'(err_pulse), 1);

    // reprogram with simultaneous key dropped
    enter4(1, 2, 3, 4);
    chk("t4_unlock", int'(unlock), 1);
    prog_pulse(1'b1, 4'd5);
    chk("t4_prog", int'(prog_mode), 1);
    chk("t4_unlock_drop", int'(unlock), 0);
    chk("t4_key_dropped", int'(digit_cnt), 0);
    enter4(9, 8, 7, 6);
    chk("t4_store_ok", int'(ok_pulse), 1);
    enter4(1, 2, 3, 4);
    chk("t4_old_err", int'(err_pulse), 1);
    enter4(9, 8, 7, 6);
    chk("t4_new_open", int'(unlock), 1);

    // short entry in PROG, abort keeps PIN
    prog_pulse(1'b0, 4'd0);
    press(9); press(8); press(4'hB);
    chk("t5_err", int'(err_pulse), 1);
    chk("t5_still_prog", int'(prog_mode), 1);
    press(4'hA);
    chk("t5_abort", int'(prog_mode), 0);
    enter4(9, 8, 7, 6);
    chk("t5_pin_kept", int'(unlock), 1);

    // reset while unlocked reverts PIN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t6_reset_unlock", int'(unlock), 0);
    enter4(1, 2, 3, 4);
    chk("t6_default_open", int'(unlock), 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 2: begin
          p = pin;
          for (int i = 0; i < PL; i++) press(4'(p[i]));
          press(4'hB);
        end
        3: begin
          for (int i = 0; i < int'($urandom_range(2, 5)); i++) press(4'($urandom_range(0, 9)));
          press(4'hB);
        end
        4, 5: prog_pulse(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        6: idle($urandom_range(0, 12));
        7: begin
          if ($urandom_range(0, 5) == 0) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
          end else idle(1);
        end
        default: begin
          press(4'($urandom_range(0, 15)));
          idle($urandom_range(0, 2));
        end
      endcase
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
